signed_addsub_bist: RTL

Self-test sequencer that drives the other end of the signed add/sub interface.
- Generates every operand/op combination and presents it on the add/sub input bus.
- Samples the 4-bit result and compares it against an internal golden model.
- Reports pass/fail, a saturating error count, and the first failing vector.
- Sits beside the add/sub tile and is used for on-silicon and regression self-checking.

---
 rtl/signed_addsub_pkg.sv | 45 ++++
 rtl/signed_addsub_golden.sv | 13 +
 rtl/signed_addsub_bist.sv | 130 +++++++++++++
 3 files changed

// File: rtl/signed_addsub_pkg.sv
// Shared definitions for the signed add/sub tile, its BIST and benches.
// Op encoding and golden arithmetic live here so every user agrees on them.
package signed_addsub_pkg;

    localparam int NUM_VECTORS = 1024;
    localparam int OPND_W      = 4;
    localparam int RES_W       = 4;
    localparam int VEC_W       = 10;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,  // A + B
        OP_SUB  = 2'b01,  // A - B
        OP_RSUB = 2'b10,  // B - A
        OP_NEG  = 2'b11   // -A
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Sign-extend to one extra bit, operate, then wrap back to RES_W bits.
    function automatic logic [RES_W-1:0] golden_result(
        input op_e               op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        logic [OPND_W:0] ax;
        logic [OPND_W:0] bx;
        logic [OPND_W:0] r;
        ax = {a[OPND_W-1], a};
        bx = {b[OPND_W-1], b};
        case (op)
            OP_ADD:  r = ax + bx;
            OP_SUB:  r = ax - bx;
            OP_RSUB: r = bx - ax;
            default: r = -ax;
        endcase
        return r[RES_W-1:0];
    endfunction

endpackage

// File: rtl/signed_addsub_golden.sv
// Combinational reference for one add/sub vector; also usable as a bench scoreboard.
module signed_addsub_golden
    import signed_addsub_pkg::*;
(
    input  op_e               op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0]  result
);

    assign result = golden_result(op, a, b);

endmodule

// File: rtl/signed_addsub_bist.sv
// Self-test sequencer: sweeps every op/A/B vector through the add/sub tile,
// checks each result against the golden model, and records pass/fail.
module signed_addsub_bist
    import signed_addsub_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [7:0]       dut_ui_in,
    output logic [1:0]       dut_uio_in,
    input  logic [3:0]       dut_uo_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [9:0]       fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e           state, state_nxt;
    logic [VEC_W-1:0] vec_idx;
    logic [CNT_W-1:0] settle_cnt;
    logic             seen_fail;
    logic [RES_W-1:0] golden;
    logic             start_sweep;
    logic             mismatch;
    logic             last_vec;

    signed_addsub_golden u_golden (
        .op     (op_e'(vec_idx[9:8])),
        .a      (vec_idx[7:4]),
        .b      (vec_idx[3:0]),
        .result (golden)
    );

    always_comb begin
        start_sweep = start && !abort && (state == ST_IDLE || state == ST_DONE);
        mismatch    = (state == ST_CHECK) && (dut_uo_out != golden);
        last_vec    = (vec_idx == VEC_W'(NUM_VECTORS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nxt = ST_DRIVE;
                ST_DRIVE:         state_nxt = ST_WAIT;
                ST_WAIT:          if (settle_cnt == '0) state_nxt = ST_CHECK;
                ST_CHECK:         state_nxt = last_vec ? ST_DONE : ST_DRIVE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx    <= '0;
            settle_cnt <= '0;
            seen_fail  <= 1'b0;
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
        end else if (abort) begin
            // Results are kept so a debugger can inspect an interrupted sweep.
            vec_idx    <= '0;
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_sweep) begin
                        vec_idx   <= '0;
                        seen_fail <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    dut_ui_in  <= vec_idx[7:0];
                    dut_uio_in <= vec_idx[9:8];
                    settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                end
                ST_WAIT: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        // Sticky flag, so a saturated counter can't re-arm capture.
                        if (!seen_fail) begin
                            seen_fail <= 1'b1;
                            fail_vec  <= vec_idx;
                        end
                    end
                    if (last_vec) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !(seen_fail || mismatch);
                    end else begin
                        vec_idx <= vec_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
